sd_block_sequencer: RTL and testbench
=====================================

SD_BLOCK_SEQUENCER -- requirements
Module: sd_block_sequencer

Interface
REQ-001 Parameter MAX_RETRY, default 3: max re-issues of one block command after an error result (0..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: max sdClk cycles waiting for a result word (1..2^24-1).
REQ-003 sdClk  in  1  single clock; all logic rising-edge.
REQ-004 sysRst  in  1  synchronous, active-high reset.
REQ-005 reqValid/reqReady  in/out  1/1  transfer-request handshake; accepted on cycle with both high.
REQ-006 reqWrite  in  1  1 = write (CMD24), 0 = read (CMD17).
REQ-007 reqBlock  in  32  first block address; reqCount  in  16  number of blocks (0 = none).
REQ-008 abort  in  1  terminate current transfer.
REQ-009 cmdFifoData  out  72  command word; cmdFifoWrEn  out  1; cmdFifoFull  in  1.
REQ-010 resultFifoData  in  36  result word; resultFifoEmpty  in  1; resultFifoRdEn  out  1 (non-FWFT: data valid cycle after rdEn).
REQ-011 busy  out  1; donePulse  out  1; error  out  1; errCode  out  4; blocksDone  out  16.

Function
REQ-012 Command word: [71:64]=0, [63:58]=6'd17 read / 6'd24 write, [57:32]=0, [31:0]=current block address.
REQ-013 Result word: [35:32]=status (4'h0 success, nonzero error), [31:0] card response, ignored by this block.
REQ-014 States: IDLE, ISSUE, WAIT, POP, CHECK, DONE, FAIL.
REQ-015 IDLE: reqReady=1; on accept latch reqWrite/reqBlock/reqCount, clear blocksDone, retry counter, error, errCode; reqCount=0 -> DONE, else -> ISSUE.
REQ-016 ISSUE: assert cmdFifoWrEn one cycle only when cmdFifoFull=0, then -> WAIT; while full, stall in ISSUE with WrEn low.
REQ-017 WAIT: timeout counter increments each cycle; resultFifoEmpty=0 -> assert resultFifoRdEn one cycle, -> POP; counter reaching TIMEOUT_CYCLES -> error path with errCode 4'hE.
REQ-018 POP: one cycle, resultFifoRdEn low; -> CHECK, sampling resultFifoData.
REQ-019 CHECK: status 0 -> blocksDone+1, address+1, retry=0; blocksDone==reqCount -> DONE, else ISSUE.
REQ-020 Error path (nonzero status or timeout): retry<MAX_RETRY -> retry+1, re-ISSUE same address; else errCode=status (or 4'hE), -> FAIL.
REQ-021 Block address increments modulo 2^32; wrap from 32'hFFFFFFFF to 0 is not an error.
REQ-022 DONE: donePulse=1 one cycle, -> IDLE. FAIL: donePulse=1 and error=1 one cycle, error stays 1 until next accept, -> IDLE.
REQ-023 abort seen in ISSUE (before WrEn) -> FAIL with errCode 4'hA immediately; in WAIT/POP/CHECK the outstanding result is consumed first, then FAIL 4'hA; abort in IDLE ignored.
REQ-024 Exactly one command outstanding at any time; never read the result FIFO outside WAIT.
REQ-025 busy=1 in every state except IDLE; reqReady=0 whenever busy.
REQ-026 cmdFifoWrEn and resultFifoRdEn never asserted in the same cycle.
REQ-027 Timeout counter clears on every ISSUE entry.

Reset
REQ-028 sysRst high at any clock edge -> IDLE next cycle, overriding all other inputs including abort and mid-transfer state.
REQ-029 Reset values: reqReady=1, busy=0, cmdFifoWrEn=0, resultFifoRdEn=0, donePulse=0, error=0, errCode=0, blocksDone=0, cmdFifoData=0.
REQ-030 After reset, no FIFO access occurs until a new request is accepted.

Verification
REQ-031 Read reqBlock=0x100, reqCount=3, all results status 0 -> words cmd 17 addr 0x100/0x101/0x102, blocksDone=3, donePulse, error=0.
REQ-032 Write count=1, first result status 4'h3, second 4'h0 -> two CMD24 words to same address, error=0, blocksDone=1.
REQ-033 MAX_RETRY=3, every result status 4'h5 -> 4 issues, then FAIL, error=1, errCode=5, blocksDone=0.
REQ-034 cmdFifoFull held high 10 cycles during ISSUE -> no WrEn while full; exactly one write when released.
REQ-035 No result within TIMEOUT_CYCLES with MAX_RETRY=0 -> FAIL, errCode=4'hE; reqBlock=0xFFFFFFFF, count=2 -> second address 0.
REQ-036 sysRst asserted in WAIT -> REQ-029 values next cycle; abort in WAIT -> result popped, then FAIL errCode 4'hA.

Source files
------------

// File: rtl/sd_block_sequencer.sv
// -----------------------------------------------------------------------------
// sd_block_sequencer
//
// Purpose:
//   Turns a multi-block transfer request into a sequence of single-block SD
//   commands (CMD17 read / CMD24 write). Exactly one command is outstanding at
//   a time. Each command's result word is popped and checked. A failing block
//   is re-issued up to MAX_RETRY times. The transfer ends with a one-cycle
//   donePulse, with error/errCode set when it fails.
//
// Ports:
//   sdClk, sysRst            clock, synchronous active-high reset
//   reqValid/reqReady        transfer-request handshake
//   reqWrite                 1 = write (CMD24), 0 = read (CMD17)
//   reqBlock, reqCount       first block address, number of blocks (0 = none)
//   abort                    terminate current transfer (errCode 4'hA)
//   cmdFifoData/WrEn/Full    72-bit command word FIFO write side
//   resultFifoData/Empty/RdEn 36-bit result FIFO read side (data valid one
//                            cycle after RdEn)
//   busy, donePulse, error, errCode, blocksDone   status outputs
// -----------------------------------------------------------------------------
module sd_block_sequencer #(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        sdClk,
  input  logic        sysRst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqBlock,
  input  logic [15:0] reqCount,
  input  logic        abort,
  output logic [71:0] cmdFifoData,
  output logic        cmdFifoWrEn,
  input  logic        cmdFifoFull,
  input  logic [35:0] resultFifoData,
  input  logic        resultFifoEmpty,
  output logic        resultFifoRdEn,
  output logic        busy,
  output logic        donePulse,
  output logic        error,
  output logic [3:0]  errCode,
  output logic [15:0] blocksDone
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    POP   = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    FAIL  = 3'd6
  } state_t;

  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  CODE_ABORT   = 4'hA;
  localparam logic [3:0]  CODE_TIMEOUT = 4'hE;

  state_t      state;
  logic        writeR;
  logic [31:0] addrR;
  logic [15:0] countR;
  logic [3:0]  retryCnt;
  logic [23:0] timeoutCnt;
  logic        abortPending;

  logic [3:0]  resultStatus;
  logic        abortNow;
  logic        unusedResp;

  // The card response field is carried by the FIFO but not interpreted here.
  assign unusedResp   = ^resultFifoData[31:0];
  assign resultStatus = resultFifoData[35:32];
  // An abort seen now or earlier in the WAIT/POP/CHECK window.
  assign abortNow     = abortPending | abort;

  // Builds the single-block command word for the current address.
  function automatic logic [71:0] buildCmd(input logic wr, input logic [31:0] addr);
    logic [5:0] opcode;
    opcode = wr ? 6'd24 : 6'd17;
    return {8'h00, opcode, 26'h0000000, addr};
  endfunction

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge sdClk) begin
    if (sysRst) begin
      state          <= IDLE;
      reqReady       <= 1'b1;
      busy           <= 1'b0;
      cmdFifoWrEn    <= 1'b0;
      cmdFifoData    <= 72'h0;
      resultFifoRdEn <= 1'b0;
      donePulse      <= 1'b0;
      error          <= 1'b0;
      errCode        <= 4'h0;
      blocksDone     <= 16'h0;
      writeR         <= 1'b0;
      addrR          <= 32'h0;
      countR         <= 16'h0;
      retryCnt       <= 4'h0;
      timeoutCnt     <= 24'h0;
      abortPending   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      cmdFifoWrEn    <= 1'b0;
      resultFifoRdEn <= 1'b0;
      donePulse      <= 1'b0;

      case (state)
        IDLE: begin
          if (reqValid && reqReady) begin
            writeR       <= reqWrite;
            addrR        <= reqBlock;
            countR       <= reqCount;
            blocksDone   <= 16'h0;
            retryCnt     <= 4'h0;
            error        <= 1'b0;
            errCode      <= 4'h0;
            abortPending <= 1'b0;
            timeoutCnt   <= 24'h0;
            reqReady     <= 1'b0;
            busy         <= 1'b1;
            if (reqCount == 16'h0) begin
              state     <= DONE;
              donePulse <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // Nothing is outstanding yet, so abort can fail immediately.
          if (abort) begin
            state     <= FAIL;
            donePulse <= 1'b1;
            error     <= 1'b1;
            errCode   <= CODE_ABORT;
          end else if (!cmdFifoFull) begin
            cmdFifoWrEn <= 1'b1;
            cmdFifoData <= buildCmd(writeR, addrR);
            timeoutCnt  <= 24'h0;
            state       <= WAIT;
          end
        end

        WAIT: begin
          abortPending <= abortNow;
          if (!resultFifoEmpty) begin
            resultFifoRdEn <= 1'b1;
            state          <= POP;
          end else if (timeoutCnt == TIMEOUT_LAST) begin
            if (abortNow) begin
              state     <= FAIL;
              donePulse <= 1'b1;
              error     <= 1'b1;
              errCode   <= CODE_ABORT;
            end else if (retryCnt < RETRY_LIMIT) begin
              retryCnt   <= retryCnt + 4'd1;
              timeoutCnt <= 24'h0;
              state      <= ISSUE;
            end else begin
              state     <= FAIL;
              donePulse <= 1'b1;
              error     <= 1'b1;
              errCode   <= CODE_TIMEOUT;
            end
          end else begin
            timeoutCnt <= timeoutCnt + 24'd1;
          end
        end

        POP: begin
          // RdEn is high during this cycle; the word is valid in CHECK.
          abortPending <= abortNow;
          state        <= CHECK;
        end

        CHECK: begin
          if (abortNow) begin
            state     <= FAIL;
            donePulse <= 1'b1;
            error     <= 1'b1;
            errCode   <= CODE_ABORT;
          end else if (resultStatus == 4'h0) begin
            blocksDone <= blocksDone + 16'd1;
            addrR      <= addrR + 32'd1;  // wraps modulo 2^32 by design
            retryCnt   <= 4'h0;
            if ((blocksDone + 16'd1) == countR) begin
              state     <= DONE;
              donePulse <= 1'b1;
            end else begin
              timeoutCnt <= 24'h0;
              state      <= ISSUE;
            end
          end else if (retryCnt < RETRY_LIMIT) begin
            retryCnt   <= retryCnt + 4'd1;
            timeoutCnt <= 24'h0;
            state      <= ISSUE;
          end else begin
            state     <= FAIL;
            donePulse <= 1'b1;
            error     <= 1'b1;
            errCode   <= resultStatus;
          end
        end

        DONE, FAIL: begin
          // error/errCode hold until the next accepted request.
          state    <= IDLE;
          reqReady <= 1'b1;
          busy     <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sd_block_sequencer
//
// Self-checking bench. Expected command words and completion status are pushed
// into scoreboard queues when a request is driven. A negedge monitor pops and
// compares them as the DUT writes commands and pulses done. A behavioural
// non-FWFT result FIFO answers each command from a per-test response plan.
// A second instance (MAX_RETRY=0, short timeout) covers the timeout path.
// -----------------------------------------------------------------------------
module tb_sd_block_sequencer;

  localparam int DROP = 16;  // response-plan entry: command gets no result

  typedef struct {
    logic        err;
    logic [3:0]  code;
    logic [15:0] blocks;
  } doneExp_t;

  logic        sdClk;
  logic        sysRst;
  logic        reqValid, reqReady, reqWrite, abort;
  logic [31:0] reqBlock;
  logic [15:0] reqCount;
  logic [71:0] cmdFifoData;
  logic        cmdFifoWrEn, cmdFifoFull;
  logic [35:0] resultFifoData;
  logic        resultFifoEmpty, resultFifoRdEn;
  logic        busy, donePulse, error;
  logic [3:0]  errCode;
  logic [15:0] blocksDone;

  logic        tReqValid, tReqReady;
  logic [71:0] tCmdFifoData;
  logic        tCmdFifoWrEn, tResultFifoRdEn;
  logic        tBusy, tDonePulse, tError;
  logic [3:0]  tErrCode;
  logic [15:0] tBlocksDone;

  int checks = 0;
  int errors = 0;
  int cmdWrites = 0;
  int pops = 0;
  int doneSeen = 0;
  int tWrites = 0;

  logic [71:0] expCmd[$];
  int          respPlan[$];
  int          resultQ[$];
  doneExp_t    doneQ[$];

  sd_block_sequencer #(.MAX_RETRY(3), .TIMEOUT_CYCLES(200)) dut (
    .sdClk(sdClk), .sysRst(sysRst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqBlock(reqBlock), .reqCount(reqCount), .abort(abort),
    .cmdFifoData(cmdFifoData), .cmdFifoWrEn(cmdFifoWrEn), .cmdFifoFull(cmdFifoFull),
    .resultFifoData(resultFifoData), .resultFifoEmpty(resultFifoEmpty),
    .resultFifoRdEn(resultFifoRdEn),
    .busy(busy), .donePulse(donePulse), .error(error), .errCode(errCode),
    .blocksDone(blocksDone)
  );

  sd_block_sequencer #(.MAX_RETRY(0), .TIMEOUT_CYCLES(40)) dutTo (
    .sdClk(sdClk), .sysRst(sysRst),
    .reqValid(tReqValid), .reqReady(tReqReady), .reqWrite(1'b0),
    .reqBlock(32'h0000_0042), .reqCount(16'd1), .abort(1'b0),
    .cmdFifoData(tCmdFifoData), .cmdFifoWrEn(tCmdFifoWrEn), .cmdFifoFull(1'b0),
    .resultFifoData(36'h0), .resultFifoEmpty(1'b1),
    .resultFifoRdEn(tResultFifoRdEn),
    .busy(tBusy), .donePulse(tDonePulse), .error(tError), .errCode(tErrCode),
    .blocksDone(tBlocksDone)
  );

  initial sdClk = 1'b0;
  always #5 sdClk = ~sdClk;

  function automatic logic [71:0] expWord(input logic wr, input logic [31:0] addr);
    logic [5:0] op;
    op = wr ? 6'd24 : 6'd17;
    return {8'h00, op, 26'h0, addr};
  endfunction

  // Monitor, scoreboard and behavioural result FIFO, all sampled at negedge.
  always @(negedge sdClk) begin
    logic [71:0] e;
    doneExp_t    d;
    logic [3:0]  st;
    int          s;
    if (cmdFifoWrEn || resultFifoRdEn) begin
      checks++;
      if (cmdFifoWrEn && resultFifoRdEn) begin
        errors++;
        $display("FAIL wr_rd_overlap: WrEn=%b RdEn=%b, required never both", cmdFifoWrEn, resultFifoRdEn);
      end
    end
    if (cmdFifoWrEn) begin
      cmdWrites++;
      checks++;
      if (cmdFifoFull) begin
        errors++;
        $display("FAIL write_while_full: WrEn=1 with cmdFifoFull=1, required WrEn=0");
      end else if (expCmd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got %h, required no command", cmdFifoData);
      end else begin
        e = expCmd.pop_front();
        if (cmdFifoData !== e) begin
          errors++;
          $display("FAIL cmd_word: got %h, required %h", cmdFifoData, e);
        end
      end
      if (respPlan.size() > 0) begin
        s = respPlan.pop_front();
        if (s < DROP) resultQ.push_back(s);
      end
    end
    if (resultFifoRdEn) begin
      pops++;
      checks++;
      if (resultQ.size() == 0) begin
        errors++;
        $display("FAIL read_empty: RdEn=1 with empty result FIFO, required RdEn=0");
      end else begin
        s  = resultQ.pop_front();
        st = s[3:0];
        resultFifoData = {st, 32'hCAFE_0000};
      end
    end
    resultFifoEmpty = (resultQ.size() == 0);
    if (donePulse) begin
      doneSeen++;
      checks++;
      if (doneQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: error=%b errCode=%h blocksDone=%0d, required no done", error, errCode, blocksDone);
      end else begin
        d = doneQ.pop_front();
        if ({error, errCode, blocksDone} !== {d.err, d.code, d.blocks}) begin
          errors++;
          $display("FAIL done_status: got error=%b errCode=%h blocksDone=%0d, required error=%b errCode=%h blocksDone=%0d",
                   error, errCode, blocksDone, d.err, d.code, d.blocks);
        end
      end
    end
    if (tCmdFifoWrEn) tWrites++;
    if (tResultFifoRdEn) begin
      checks++;
      errors++;
      $display("FAIL to_read: timeout instance RdEn=1, required 0");
    end
  end

  task automatic doRequest(input logic wr, input logic [31:0] blk, input logic [15:0] cnt);
    bit acc;
    acc = 1'b0;
    @(negedge sdClk);
    reqValid = 1'b1; reqWrite = wr; reqBlock = blk; reqCount = cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge sdClk);
      if (!reqReady) begin acc = 1'b1; break; end
    end
    reqValid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL req_accept: reqReady stayed 1, required accept");
    end
  endtask

  task automatic waitDone(input int d0, input int budget);
    bit seen;
    seen = (doneSeen > d0);
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge sdClk); #1;
      seen = (doneSeen > d0);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no donePulse within %0d cycles", budget);
    end
  endtask

  task automatic checkDrained(input string name);
    checks++;
    if (expCmd.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d expected commands left, required 0", name, expCmd.size());
      expCmd.delete();
    end
  endtask

  task automatic checkResetValues(input string name);
    checks++;
    if ({reqReady, busy, cmdFifoWrEn, resultFifoRdEn, donePulse, error, errCode, blocksDone, cmdFifoData}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 72'h0}) begin
      errors++;
      $display("FAIL %s: rdy=%b busy=%b wr=%b rd=%b done=%b err=%b code=%h blk=%0d cmd=%h, required 1 0 0 0 0 0 0 0 0",
               name, reqReady, busy, cmdFifoWrEn, resultFifoRdEn, donePulse, error, errCode, blocksDone, cmdFifoData);
    end
  endtask

  task automatic test_reset();
    sysRst = 1'b1;
    repeat (3) @(negedge sdClk);
    checkResetValues("reset_values");
    sysRst = 1'b0;
  endtask

  task automatic test_read3();
    int d0;
    for (int i = 0; i < 3; i++) begin
      expCmd.push_back(expWord(1'b0, 32'h100 + 32'(i)));
      respPlan.push_back(0);
    end
    doneQ.push_back('{1'b0, 4'h0, 16'd3});
    d0 = doneSeen;
    doRequest(1'b0, 32'h100, 16'd3);
    waitDone(d0, 300);
    checkDrained("read3");
  endtask

  task automatic test_write_retry_ok();
    int d0;
    int w0;
    expCmd.push_back(expWord(1'b1, 32'h2000));
    expCmd.push_back(expWord(1'b1, 32'h2000));
    respPlan.push_back(3);
    respPlan.push_back(0);
    doneQ.push_back('{1'b0, 4'h0, 16'd1});
    d0 = doneSeen; w0 = cmdWrites;
    doRequest(1'b1, 32'h2000, 16'd1);
    waitDone(d0, 300);
    checkDrained("retry_ok");
    checks++;
    if (cmdWrites - w0 != 2) begin
      errors++;
      $display("FAIL retry_ok_writes: got %0d writes, required 2", cmdWrites - w0);
    end
  endtask

  task automatic test_retry_exhaust();
    int d0;
    for (int i = 0; i < 4; i++) begin
      expCmd.push_back(expWord(1'b0, 32'h300));
      respPlan.push_back(5);
    end
    doneQ.push_back('{1'b1, 4'h5, 16'd0});
    d0 = doneSeen;
    doRequest(1'b0, 32'h300, 16'd2);
    waitDone(d0, 400);
    checkDrained("retry_fail");
    @(negedge sdClk); #1;
    checks++;
    if ({donePulse, error, errCode, busy} !== {1'b0, 1'b1, 4'h5, 1'b0}) begin
      errors++;
      $display("FAIL fail_hold: got done=%b error=%b errCode=%h busy=%b, required 0 1 5 0",
               donePulse, error, errCode, busy);
    end
  endtask

  task automatic test_full_stall();
    int d0;
    int w0;
    cmdFifoFull = 1'b1;
    expCmd.push_back(expWord(1'b1, 32'h700));
    respPlan.push_back(0);
    doneQ.push_back('{1'b0, 4'h0, 16'd1});
    d0 = doneSeen; w0 = cmdWrites;
    doRequest(1'b1, 32'h700, 16'd1);
    repeat (10) @(negedge sdClk);
    checks++;
    if (cmdWrites != w0) begin
      errors++;
      $display("FAIL full_stall: got %0d writes while full, required 0", cmdWrites - w0);
    end
    cmdFifoFull = 1'b0;
    waitDone(d0, 300);
    checks++;
    if (cmdWrites - w0 != 1) begin
      errors++;
      $display("FAIL full_release: got %0d writes, required 1", cmdWrites - w0);
    end
    checkDrained("full");
  endtask

  task automatic test_wrap();
    int d0;
    expCmd.push_back(expWord(1'b0, 32'hFFFF_FFFF));
    expCmd.push_back(expWord(1'b0, 32'h0000_0000));
    respPlan.push_back(0);
    respPlan.push_back(0);
    doneQ.push_back('{1'b0, 4'h0, 16'd2});
    d0 = doneSeen;
    doRequest(1'b0, 32'hFFFF_FFFF, 16'd2);
    waitDone(d0, 300);
    checkDrained("wrap");
  endtask

  task automatic test_count_zero();
    int d0;
    int w0;
    doneQ.push_back('{1'b0, 4'h0, 16'd0});
    d0 = doneSeen; w0 = cmdWrites;
    doRequest(1'b0, 32'h55, 16'd0);
    waitDone(d0, 20);
    checks++;
    if (cmdWrites != w0) begin
      errors++;
      $display("FAIL count_zero: got %0d writes, required 0", cmdWrites - w0);
    end
  endtask

  task automatic test_timeout();
    bit acc;
    bit seen;
    int n;
    acc = 1'b0; seen = 1'b0; n = 0;
    @(negedge sdClk);
    tReqValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sdClk);
      if (!tReqReady) begin acc = 1'b1; break; end
    end
    tReqValid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL to_accept: reqReady stayed 1, required accept");
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge sdClk);
      n++;
      seen = tDonePulse;
    end
    checks++;
    if (!seen || n < 40 || n > 44) begin
      errors++;
      $display("FAIL to_latency: done seen=%b after %0d cycles, required seen in 40..44", seen, n);
    end
    checks++;
    if ({tError, tErrCode, tBlocksDone, 32'(tWrites)} !== {1'b1, 4'hE, 16'd0, 32'd1}) begin
      errors++;
      $display("FAIL to_status: got error=%b errCode=%h blocksDone=%0d writes=%0d, required 1 E 0 1",
               tError, tErrCode, tBlocksDone, tWrites);
    end
  endtask

  task automatic test_reset_in_wait();
    int w0;
    int p0;
    expCmd.push_back(expWord(1'b0, 32'h500));
    respPlan.push_back(DROP);
    doRequest(1'b0, 32'h500, 16'd1);
    repeat (5) @(negedge sdClk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_busy: got busy=%b, required 1", busy);
    end
    sysRst = 1'b1;
    abort  = 1'b1;
    @(negedge sdClk);
    checkResetValues("reset_in_wait");
    sysRst = 1'b0;
    abort  = 1'b0;
    w0 = cmdWrites; p0 = pops;
    repeat (15) @(negedge sdClk);
    checks++;
    if (cmdWrites != w0 || pops != p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: writes=%0d pops=%0d busy=%b, required 0 0 0",
               cmdWrites - w0, pops - p0, busy);
    end
    checkDrained("reset_wait");
  endtask

  task automatic test_abort_in_wait();
    int d0;
    int p0;
    expCmd.push_back(expWord(1'b0, 32'h900));
    respPlan.push_back(DROP);
    doneQ.push_back('{1'b1, 4'hA, 16'd0});
    d0 = doneSeen;
    doRequest(1'b0, 32'h900, 16'd2);
    repeat (4) @(negedge sdClk);
    abort = 1'b1;
    @(negedge sdClk);
    abort = 1'b0;
    repeat (5) @(negedge sdClk);
    checks++;
    if (doneSeen != d0) begin
      errors++;
      $display("FAIL abort_early: done before result consumed, required wait for result");
    end
    p0 = pops;
    @(negedge sdClk); #1;
    resultQ.push_back(0);
    resultFifoEmpty = 1'b0;
    waitDone(d0, 50);
    checks++;
    if (pops - p0 != 1) begin
      errors++;
      $display("FAIL abort_pop: got %0d pops, required 1", pops - p0);
    end
    checkDrained("abort");
  endtask

  initial begin
    sysRst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqBlock = 32'h0; reqCount = 16'h0;
    abort = 1'b0; cmdFifoFull = 1'b0; resultFifoEmpty = 1'b1; resultFifoData = 36'h0;
    tReqValid = 1'b0;
    test_reset();
    test_read3();
    test_write_retry_ok();
    test_retry_exhaust();
    test_full_stall();
    test_wrap();
    test_count_zero();
    test_timeout();
    test_reset_in_wait();
    test_abort_in_wait();
    repeat (3) @(negedge sdClk);
    checks++;
    if (doneQ.size() != 0) begin
      errors++;
      $display("FAIL done_drained: %0d expected completions left, required 0", doneQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
